// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared definitions for the product-to-BCD converter.
//               Converter FSM state encoding, default product width and
//               digit count, and the double-dabble add-3 threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

    // A digit at or above this value overflows past 9 when doubled, so it is
    // pre-corrected by +3 before the shift.
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/product_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_converter_if
// Description : Request/result bundle between a product source and the
//               BCD converter.
//   Start   - request a conversion of Product (master -> slave)
//   Product - value to convert (master -> slave)
//   Busy    - conversion in flight, through the Done cycle (slave -> master)
//   Done    - one-cycle pulse, new result valid (slave -> master)
//   Neg     - sign of the last converted product (slave -> master)
//   Bcd     - packed BCD magnitude, digit 0 in [3:0] (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface product_bcd_converter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
);

    logic                  Start;
    logic [WIDTH-1:0]      Product;
    logic                  Busy;
    logic                  Done;
    logic                  Neg;
    logic [4*DIGITS-1:0]   Bcd;

    modport master (
        output Start,
        output Product,
        input  Busy,
        input  Done,
        input  Neg,
        input  Bcd
    );

    modport slave (
        input  Start,
        input  Product,
        output Busy,
        output Done,
        output Neg,
        output Bcd
    );

endinterface : product_bcd_converter_if
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction: passes a 4-bit BCD digit
//               through unchanged, or adds 3 when it is at or above the
//               threshold, so the following left shift stays in BCD range.
//   value    - scratch digit before the shift
//   adjusted - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  wire logic [3:0] value,
    output logic      [3:0] adjusted
);

    assign adjusted = (value >= ADD3_THRESHOLD) ? (value + 4'd3) : value;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_converter
// Description : Converts a multiplier product to sign + packed BCD magnitude
//               with a serial shift-and-add-3 engine, one bit per clock.
//   Clk   - system clock, rising edge
//   Reset - synchronous, active-low
//   bus   - product_bcd_converter_if slave (Start/Product in,
//           Busy/Done/Neg/Bcd out)
// Configuration:
//   PRODUCT_BCD_SIGNED_EN - when defined, Product is two's complement and
//                           Neg reports its sign; otherwise Product is
//                           unsigned and Neg is always 0.
// Revision    : 1.0 - initial release
// ============================================================================
module product_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
)(
    input  wire logic               Clk,
    input  wire logic               Reset,
    product_bcd_converter_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = 4 * DIGITS;

    state_t            r_state;
    logic [CW-1:0]     r_counter;
    logic [DW-1:0]     r_scratch;
    logic [WIDTH-1:0]  r_mag;
    logic              r_sign;

    logic [WIDTH-1:0]  w_magnitude;
    logic              w_sign;
    logic [DW-1:0]     w_adj;
    logic [DW-1:0]     w_shift_digits;

`ifdef PRODUCT_BCD_SIGNED_EN
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no overflow handling is needed.
    assign w_sign      = bus.Product[WIDTH-1];
    assign w_magnitude = w_sign ? (~bus.Product + 1'b1) : bus.Product;
`else
    assign w_sign      = 1'b0;
    assign w_magnitude = bus.Product;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .value    (r_scratch[4*g +: 4]),
            .adjusted (w_adj[4*g +: 4])
        );
    end

    // Shift corrected digits left, bringing in the magnitude MSB. The top
    // bit of the corrected digits falls off; with enough digits it is 0.
    assign w_shift_digits = DW'({w_adj, r_mag[WIDTH-1]});

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_scratch <= '0;
            r_mag     <= '0;
            r_sign    <= 1'b0;
            bus.Busy  <= 1'b0;
            bus.Done  <= 1'b0;
            bus.Neg   <= 1'b0;
            bus.Bcd   <= '0;
        end else begin
            bus.Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_mag     <= w_magnitude;
                        r_sign    <= w_sign;
                        r_scratch <= '0;
                        r_counter <= CW'(WIDTH);
                        bus.Busy  <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shift_digits;
                    r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
                    r_counter <= r_counter - CW'(1);
                    // Last shift: publish its result directly so the
                    // outputs land on the edge that enters DONE.
                    if (r_counter == CW'(1)) begin
                        bus.Bcd  <= w_shift_digits;
                        bus.Neg  <= r_sign;
                        bus.Done <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    bus.Busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    bus.Busy <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule : product_bcd_converter
`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_bcd_converter
// Description : Directed self-checking bench for product_bcd_converter.
//               Cycle numbering: the clock period in which Start is presented
//               is cycle 0; the period after the accepting edge is cycle 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_bcd_converter;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    product_bcd_converter_if bus ();

    product_bcd_converter dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full conversion with latency, result, pulse width and Busy checks.
    task automatic run_conv(input string tag, input logic [15:0] p,
                            input logic [19:0] exp_bcd, input logic exp_neg);
        int c;
        bus.Product = p;
        bus.Start   = 1'b1;
        tick();
        bus.Start   = 1'b0;
        bus.Product = 16'h0000;
        c = 1;
        check({tag, " busy_after_accept"}, 32'(bus.Busy), 32'd1);
        while (!bus.Done && c < 40) begin
            tick();
            c++;
        end
        check({tag, " done_cycle"}, c, 32'd17);
        check({tag, " bcd"}, 32'(bus.Bcd), 32'(exp_bcd));
        check({tag, " neg"}, 32'(bus.Neg), 32'(exp_neg));
        check({tag, " busy_in_done"}, 32'(bus.Busy), 32'd1);
        tick();
        check({tag, " done_single"}, 32'(bus.Done), 32'd0);
        check({tag, " busy_low_after"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int prev;
        compared   = 0;
        mismatched = 0;

        // Reset state
        reset       = 1'b0;
        bus.Start   = 1'b0;
        bus.Product = 16'h0000;
        tick();
        tick();
        check("reset busy", 32'(bus.Busy), 32'd0);
        check("reset done", 32'(bus.Done), 32'd0);
        check("reset neg",  32'(bus.Neg),  32'd0);
        check("reset bcd",  32'(bus.Bcd),  32'h0);
        reset = 1'b1;
        tick();

        // Basic conversion and result hold
        run_conv("p3039", 16'h3039, 20'h12345, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("p3039 bcd_hold", 32'(bus.Bcd), 32'h12345);

`ifdef PRODUCT_BCD_SIGNED_EN
        run_conv("pFFFF", 16'hFFFF, 20'h00001, 1'b1);
        run_conv("p8000", 16'h8000, 20'h32768, 1'b1);
        run_conv("pCFC7", 16'hCFC7, 20'h12345, 1'b1);
`else
        run_conv("pFFFF", 16'hFFFF, 20'h65535, 1'b0);
        run_conv("p8000", 16'h8000, 20'h32768, 1'b0);
        run_conv("pCFC7", 16'hCFC7, 20'h53191, 1'b0);
`endif
        run_conv("p0000", 16'h0000, 20'h00000, 1'b0);

        // Start during SHIFT is ignored and not queued
        bus.Product = 16'h3039;
        bus.Start   = 1'b1;
        tick();
        bus.Start   = 1'b0;
        done_cnt    = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                bus.Start   = 1'b1;
                bus.Product = 16'h0001;
            end
            if (c == 6) begin
                bus.Start   = 1'b0;
                bus.Product = 16'h0000;
            end
            if (bus.Done) begin
                done_cnt++;
                check("ignore done_cycle", c, 32'd17);
                check("ignore bcd", 32'(bus.Bcd), 32'h12345);
            end
            tick();
        end
        check("ignore done_count", done_cnt, 32'd1);

        // Reset mid-conversion abandons it
        bus.Product = 16'h3039;
        bus.Start   = 1'b1;
        tick();
        bus.Start   = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", 32'(bus.Busy), 32'd0);
        check("abort bcd",  32'(bus.Bcd),  32'h0);
        check("abort done", 32'(bus.Done), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.Done) done_cnt++;
            tick();
        end
        check("abort no_done", done_cnt, 32'd0);
        run_conv("p00FF", 16'h00FF, 20'h00255, 1'b0);

        // Reset wins over Start on the same edge
        bus.Product = 16'h0064;
        bus.Start   = 1'b1;
        reset       = 1'b0;
        tick();
        reset       = 1'b1;
        bus.Start   = 1'b0;
        check("prio busy", 32'(bus.Busy), 32'd0);
        tick();
        check("prio busy_later", 32'(bus.Busy), 32'd0);

        // Start held high: back-to-back conversions, one IDLE cycle apart
        bus.Product = 16'h0064;
        bus.Start   = 1'b1;
        done_cnt    = 0;
        prev        = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.Done) begin
                done_cnt++;
                check("held bcd", 32'(bus.Bcd), 32'h00100);
                if (done_cnt == 1) check("held first_done", i, 32'd17);
                else               check("held period", i - prev, 32'd18);
                prev = i;
            end
        end
        bus.Start = 1'b0;
        check("held done_count", done_cnt, 32'd3);
        for (int i = 0; i < 40 && bus.Busy; i++) tick();
        check("held drain busy", 32'(bus.Busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_product_bcd_converter
`default_nettype wire

// File: doc/product_bcd_converter.md
PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the product input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 5, meaning the number of BCD output digits.
REQ-003 The block SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port Start  input  1  request to convert Product; sampled only in IDLE.
REQ-006 The block SHALL have port Product  input  WIDTH  multiplier result, two's complement, read on the accepting edge only.
REQ-007 The block SHALL have port Busy  output  1  high from the cycle after acceptance through the Done cycle.
REQ-008 The block SHALL have port Done  output  1  single-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port Neg  output  1  sign of the last converted product.
REQ-010 The block SHALL have port Bcd  output  4*DIGITS  magnitude of the last product, packed BCD, digit 0 in bits [3:0].

Function
REQ-011 The block SHALL implement states IDLE, SHIFT and DONE with an iteration counter of width clog2(WIDTH+1).
REQ-012 The block SHALL accept Start only at a rising edge in IDLE: latch magnitude |Product| as WIDTH-bit unsigned, latch sign, clear the digit scratch, load counter with WIDTH, go to SHIFT.
REQ-013 The block SHALL, in each SHIFT cycle, add 3 to every scratch digit >= 5, then shift {digits, magnitude} left by one, and decrement the counter.
REQ-014 The block SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles.
REQ-015 The block SHALL, on the edge that enters DONE, load Bcd and Neg from the scratch, and assert Done for that one cycle only; Done SHALL rise WIDTH+1 cycles after the accepting edge (17 for defaults).
REQ-016 The block SHALL return from DONE to IDLE unconditionally; Start seen in SHIFT or DONE SHALL be ignored, not queued.
REQ-017 The block SHALL hold Bcd and Neg stable between Done pulses.
REQ-018 The block SHALL convert -32768 (0x8000) as magnitude 32768 with Neg=1; no overflow case exists.
REQ-019 The block SHALL produce Neg=0 for a zero product.
REQ-020 The block SHALL keep Start held high continuously as one conversion per IDLE visit (back-to-back, one IDLE cycle between).

Reset
REQ-021 The block SHALL, when Reset is sampled low, go to IDLE and set Busy=0, Done=0, Neg=0, Bcd=0, counter=0, scratch=0.
REQ-022 The block SHALL abandon any in-progress conversion on reset without a Done pulse.
REQ-023 The block SHALL let Reset take priority over Start on the same edge.

Configuration
REQ-024 The block SHALL, with PRODUCT_BCD_SIGNED_EN defined, treat Product as two's complement per REQ-012.
REQ-025 The block SHALL, without PRODUCT_BCD_SIGNED_EN, treat Product as unsigned, tie Neg to 0, and omit the negation logic.

Structure
REQ-026 The block SHALL take its state enum, the default WIDTH/DIGITS constants and the add-3 threshold from shared package bcd_pkg.
REQ-027 The block SHALL instantiate DIGITS copies of sub-module bcd_digit_adj (4-bit combinational: output = in+3 when in >= 5, else in).

Verification
REQ-028 The bench SHALL check Product=0x3039, Start pulse -> Done 17 cycles later, Bcd=0x12345, Neg=0, Busy low next cycle.
REQ-029 The bench SHALL check Product=0xFFFF -> Bcd=0x00001, Neg=1 (signed build), or Bcd=0x65535, Neg=0 (unsigned build).
REQ-030 The bench SHALL check Product=0x8000 -> Bcd=0x32768, Neg=1 (signed) and Product=0x0000 -> Bcd=0x00000, Neg=0.
REQ-031 The bench SHALL check a Start with Product=0x0001 during cycle 5 of a 0x3039 conversion -> ignored; single Done with Bcd=0x12345.
REQ-032 The bench SHALL check Reset low at cycle 8 of a conversion -> IDLE, Busy=0, Bcd=0, no Done; a new Start with 0x00FF -> Bcd=0x00255.
REQ-033 The bench SHALL check Start held high for 60 cycles with Product=0x0064 -> Done every 18 cycles, Bcd=0x00100 each time.
